// File: rtl/cp0_pkg.sv
// Shared constants and types for the exception sequencer: CP0 cause codes,
// Status enable-bit positions, FSM states and the default handler address.
package cp0_pkg;

  localparam logic [4:0] CauseSys = 5'b01000;
  localparam logic [4:0] CauseBrk = 5'b01001;
  localparam logic [4:0] CauseTeq = 5'b01101;

  localparam int unsigned StatusIe  = 0;
  localparam int unsigned StatusSys = 1;
  localparam int unsigned StatusBrk = 2;
  localparam int unsigned StatusTeq = 3;

  localparam logic [31:0] ExcVectorDefault = 32'h0040_0004;
  // 32-bit Status shifted 5 bits per nesting level leaves room for six levels.
  localparam int unsigned MaxDepthDefault  = 6;
  localparam int unsigned DepthW           = 3;

  typedef enum logic [1:0] {
    StIdle,
    StTrap,
    StVec,
    StRet
  } exc_state_e;

  function automatic logic [31:0] ret_target(input logic [31:0] epc);
    return epc + 32'd4;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Masks trap requests with the CP0 Status enables and picks the winner:
// syscall beats break beats teq.
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic       syscall_req_i,
  input  logic       break_req_i,
  input  logic       teq_req_i,
  input  logic [3:0] status_en_i,
  output logic       valid_o,
  output logic [4:0] cause_o
);

  logic sys_ok;
  logic brk_ok;
  logic teq_ok;

  always_comb begin
    sys_ok  = syscall_req_i & status_en_i[StatusIe] & status_en_i[StatusSys];
    brk_ok  = break_req_i   & status_en_i[StatusIe] & status_en_i[StatusBrk];
    teq_ok  = teq_req_i     & status_en_i[StatusIe] & status_en_i[StatusTeq];
    valid_o = sys_ok | brk_ok | teq_ok;
    cause_o = '0;
    if (sys_ok) begin
      cause_o = CauseSys;
    end else if (brk_ok) begin
      cause_o = CauseBrk;
    end else if (teq_ok) begin
      cause_o = CauseTeq;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: drives CP0 exception/eret strobes, redirects fetch,
// stalls decode while a trap is in flight and tracks Status-stack depth.
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = ExcVectorDefault,
  parameter int unsigned MAX_DEPTH  = MaxDepthDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] status,
  input  logic [31:0] exc_addr,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] cp0_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall,
  output logic [2:0]  depth,
  output logic        nest_err
);

  localparam logic [DepthW-1:0] MaxDepthL = DepthW'(MAX_DEPTH);

  exc_state_e        state_q;
  logic              exception_q;
  logic              eret_q;
  logic [4:0]        cause_q;
  logic [31:0]       cp0_pc_q;
  logic              redirect_q;
  logic [31:0]       redirect_pc_q;
  logic              stall_q;
  logic [DepthW-1:0] depth_q;
  logic              nest_err_q;

  logic              exc_valid;
  logic [4:0]        exc_cause;
  logic              unused_status;

  assign unused_status = ^status[31:4];

  exc_prio_enc u_prio_enc (
    .syscall_req_i (syscall_req),
    .break_req_i   (break_req),
    .teq_req_i     (teq_req),
    .status_en_i   (status[3:0]),
    .valid_o       (exc_valid),
    .cause_o       (exc_cause)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      exception_q   <= 1'b0;
      eret_q        <= 1'b0;
      cause_q       <= '0;
      cp0_pc_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      stall_q       <= 1'b0;
      depth_q       <= '0;
      nest_err_q    <= 1'b0;
    end else begin
      exception_q <= 1'b0;
      eret_q      <= 1'b0;
      redirect_q  <= 1'b0;
      nest_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A qualified trap always shadows a simultaneous eret.
          if (exc_valid) begin
            if (depth_q < MaxDepthL) begin
              state_q     <= StTrap;
              exception_q <= 1'b1;
              cause_q     <= exc_cause;
              cp0_pc_q    <= pc_in;
              stall_q     <= 1'b1;
            end else begin
              nest_err_q <= 1'b1;
            end
          end else if (eret_req) begin
            if (depth_q != '0) begin
              state_q       <= StRet;
              eret_q        <= 1'b1;
              redirect_q    <= 1'b1;
              redirect_pc_q <= ret_target(exc_addr);
              stall_q       <= 1'b1;
            end else begin
              nest_err_q <= 1'b1;
            end
          end
        end
        StTrap: begin
          state_q       <= StVec;
          redirect_q    <= 1'b1;
          redirect_pc_q <= EXC_VECTOR;
          depth_q       <= depth_q + 1'b1;
        end
        StVec: begin
          state_q <= StIdle;
          stall_q <= 1'b0;
        end
        StRet: begin
          state_q <= StIdle;
          stall_q <= 1'b0;
          depth_q <= depth_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign exception   = exception_q;
  assign eret        = eret_q;
  assign cause       = cause_q;
  assign cp0_pc      = cp0_pc_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign stall       = stall_q;
  assign depth       = depth_q;
  assign nest_err    = nest_err_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected output cycles,
// a negedge monitor pops and compares whenever any strobe is visible.
module tb_exc_ctrl;

  typedef struct packed {
    logic        exc;
    logic        ert;
    logic        rdr;
    logic        nerr;
    logic [4:0]  cause;
    logic [31:0] cpc;
    logic [31:0] rpc;
    logic        stall;
    logic [2:0]  depth;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscall_req = 1'b0;
  logic        break_req = 1'b0;
  logic        teq_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] status = '0;
  logic [31:0] exc_addr = '0;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] cp0_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [2:0]  depth;
  logic        nest_err;

  ev_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [4:0]  m_cause = '0;
  logic [31:0] m_pc = '0;

  exc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .syscall_req (syscall_req),
    .break_req   (break_req),
    .teq_req     (teq_req),
    .eret_req    (eret_req),
    .pc_in       (pc_in),
    .status      (status),
    .exc_addr    (exc_addr),
    .exception   (exception),
    .eret        (eret),
    .cause       (cause),
    .cp0_pc      (cp0_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .depth       (depth),
    .nest_err    (nest_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ev_t mk(input logic exc, input logic ert, input logic rdr, input logic nerr,
                             input logic [31:0] rpc, input logic stl, input logic [2:0] d);
    ev_t e;
    e.exc   = exc;
    e.ert   = ert;
    e.rdr   = rdr;
    e.nerr  = nerr;
    e.cause = m_cause;
    e.cpc   = m_pc;
    e.rpc   = rdr ? rpc : 32'h0;
    e.stall = stl;
    e.depth = d;
    return e;
  endfunction

  // Monitor: every visible strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (exception || eret || redirect || nest_err) begin
      ev_t a;
      a.exc   = exception;
      a.ert   = eret;
      a.rdr   = redirect;
      a.nerr  = nest_err;
      a.cause = cause;
      a.cpc   = cp0_pc;
      a.rpc   = redirect ? redirect_pc : 32'h0;
      a.stall = stall;
      a.depth = depth;
      if (exp_q.size() == 0) begin
        check("unexpected output", 80'(a), 80'h0);
      end else begin
        check("output event", 80'(a), 80'(exp_q.pop_front()));
      end
    end
  end

  // kind: 0 syscall, 1 break, 2 teq
  task automatic do_trap(input int kind, input logic [31:0] pc, input logic [4:0] c,
                         input logic [2:0] d, input logic with_eret, input logic also_teq);
    m_cause = c;
    m_pc    = pc;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, d));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0004, 1'b1, d + 3'd1));
    pc_in       = pc;
    syscall_req = (kind == 0);
    break_req   = (kind == 1);
    teq_req     = (kind == 2) || also_teq;
    eret_req    = with_eret;
    tick();
    syscall_req = 1'b0;
    break_req   = 1'b0;
    teq_req     = 1'b0;
    eret_req    = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_eret(input logic [31:0] epc, input logic [31:0] target, input logic [2:0] d);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, target, 1'b1, d));
    exc_addr = epc;
    eret_req = 1'b1;
    tick();
    eret_req = 1'b0;
    tick();
  endtask

  task automatic do_nerr(input int kind, input logic [2:0] d);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, d));
    syscall_req = (kind == 0);
    eret_req    = (kind == 3);
    tick();
    syscall_req = 1'b0;
    eret_req    = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] causes[3];
    causes[0] = 5'b01000;
    causes[1] = 5'b01001;
    causes[2] = 5'b01101;

    tick();
    tick();
    check("reset outputs",
          80'({exception, eret, cause, cp0_pc, redirect, redirect_pc, stall, depth, nest_err}),
          80'h0);
    rst_n = 1'b1;
    tick();

    status = 32'h0000_000F;
    do_trap(0, 32'h0040_0020, 5'b01000, 3'd0, 1'b0, 1'b0);
    check("depth after first trap", 80'(depth), 80'd1);
    check("stall released", 80'(stall), 80'd0);

    // Masked requests must produce nothing at all.
    status    = 32'h0000_000B;
    break_req = 1'b1;
    tick();
    break_req = 1'b0;
    check("masked break stall", 80'(stall), 80'd0);
    status  = 32'h0;
    teq_req = 1'b1;
    tick();
    teq_req = 1'b0;
    tick();
    tick();
    check("masked teq depth", 80'(depth), 80'd1);

    do_eret(32'h0040_001C, 32'h0040_0020, 3'd1);
    check("depth after eret", 80'(depth), 80'd0);
    do_nerr(3, 3'd0);

    status = 32'h0000_000F;
    do_trap(0, 32'h0040_0100, 5'b01000, 3'd0, 1'b0, 1'b1);
    do_eret(32'h0040_0200, 32'h0040_0204, 3'd1);

    for (int i = 0; i < 6; i++) begin
      do_trap(i % 3, 32'h0040_1000 + 32'(i * 16), causes[i % 3], 3'(i), (i == 2), 1'b0);
    end
    check("depth full", 80'(depth), 80'd6);
    do_nerr(0, 3'd6);
    check("depth held at max", 80'(depth), 80'd6);

    do_eret(32'hFFFF_FFFC, 32'h0000_0000, 3'd6);
    check("depth after wrap eret", 80'(depth), 80'd5);

    // Reset sampled at the edge leaving TRAP: redirect must never appear.
    m_cause = 5'b01000;
    m_pc    = 32'h0040_0300;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd5));
    pc_in       = 32'h0040_0300;
    syscall_req = 1'b1;
    tick();
    syscall_req = 1'b0;
    rst_n       = 1'b0;
    tick();
    check("outputs after mid-trap reset",
          80'({exception, eret, cause, cp0_pc, redirect, redirect_pc, stall, depth, nest_err}),
          80'h0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("depth after reset", 80'(depth), 80'd0);
    check("scoreboard drained", 80'(exp_q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception sequencer between the decode stage and the CP0 register file. It accepts syscall, break, teq and eret requests and qualifies them against the CP0 Status enable bits. It drives CP0's exception, eret, cause and pc inputs in the correct cycle order, redirects the fetch PC, stalls the pipeline while a trap is in flight, and tracks the nesting depth of CP0's 5-bit Status shift stack.

## Interface
- EXC_VECTOR, 32'h0040_0004, handler entry address.
- MAX_DEPTH, 6, maximum nesting depth (32/5 Status shifts).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- syscall_req  in  1  decode found syscall (one-cycle pulse).
- break_req  in  1  decode found break.
- teq_req  in  1  teq with rs==rt (condition already evaluated).
- eret_req  in  1  decode found eret.
- pc_in  in  32  PC+4 of the requesting instruction.
- status  in  32  CP0 Status (reg 12).
- exc_addr  in  32  CP0 EPC (reg 14).
- exception  out  1  to CP0, one-cycle pulse.
- eret  out  1  to CP0, one-cycle pulse.
- cause  out  5  to CP0 ExcCode.
- cp0_pc  out  32  to CP0 pc input.
- redirect  out  1  fetch PC override, one-cycle pulse.
- redirect_pc  out  32  override target.
- stall  out  1  freeze fetch/decode.
- depth  out  3  current nesting depth.
- nest_err  out  1  one-cycle pulse, request refused by depth limit.

## Operation
- Enables: syscall needs status[0]&status[1]; break needs status[0]&status[2]; teq needs status[0]&status[3]. Masked requests are dropped silently.
- Priority: syscall > break > teq > eret. Only the winner is taken; the others are dropped.
- Cause codes: syscall 5'b01000, break 5'b01001, teq 5'b01101.
- FSM states: IDLE, TRAP, VEC, RET.
- IDLE + qualified exception + depth<MAX_DEPTH → TRAP. Latch the cause and pc_in.
- IDLE + qualified exception + depth==MAX_DEPTH → stay in IDLE and pulse nest_err.
- IDLE + eret_req (no exception) + depth>0 → RET.
- IDLE + eret_req + depth==0 → stay in IDLE and pulse nest_err.
- TRAP: exception=1, cause=latched, cp0_pc=latched pc, stall=1; depth+1. Next state VEC.
- VEC: redirect=1, redirect_pc=EXC_VECTOR, stall=1. Next state IDLE.
- RET: eret=1, redirect=1, redirect_pc=exc_addr+4, stall=1; depth−1. Next state IDLE.
- Requests arriving outside IDLE are ignored; decode is stalled then.
- cp0_pc and cause hold their last value outside TRAP. exception and eret are 0 outside their states.
- Arithmetic: depth is 3-bit and never wraps, clamped by the checks above. exc_addr+4 is modulo 2^32.

## Timing
- Reset values: all outputs 0, cp0_pc 0, cause 0, depth 0, state IDLE.
- Request sampled at edge E0. exception is high in cycle E0..E1, and CP0 updates at E1. redirect is high in E1..E2. stall is high E0..E2 and low from E2.
- Trap latency is 2 cycles, request to redirect.
- eret sampled at E0. eret and redirect are both high E0..E1. exc_addr is read during that cycle, before CP0's Status shift lands.
- Reset asserted in any state: IDLE at the next edge, pulses cancelled, depth 0. No partial CP0 update beyond the edge where reset is sampled.
- Exception and eret in the same cycle: exception wins, eret is dropped, no nest_err.

## Structure
- Package cp0_pkg holds the cause constants, the Status bit indices (IE=0, SYS=1, BRK=2, TEQ=3), the FSM state enum, and the EXC_VECTOR default.
- Sub-module exc_prio_enc: combinational mask plus priority encoder, producing valid and cause[4:0] from the requests and status.
- Top level holds the FSM, latches, and depth counter.

## Test plan
- status=32'h0000_000F, syscall_req at pc_in=32'h0040_0020 → next cycle exception=1, cause=5'b01000, cp0_pc=32'h0040_0020. Following cycle redirect=1, redirect_pc=32'h0040_0004, depth=1.
- status=32'h0000_000B (break masked), break_req → no exception, no stall. With status=32'h0, teq_req → no response.
- syscall_req and teq_req in the same cycle with status=32'hF → cause=5'b01000 only, single trap.
- depth=1, exc_addr=32'h0040_001C, eret_req → same cycle eret=1, redirect_pc=32'h0040_0020, depth=0. eret_req at depth 0 → nest_err=1, no eret.
- Six back-to-back qualified syscalls, each started after the previous one returns to IDLE → depth=6. A seventh request → nest_err=1, no exception pulse, depth stays 6.
- rst_n=0 in the cycle after the state enters TRAP → redirect never asserts, depth=0 and all outputs 0 at the next edge.
